biquad_sequencer: RTL

Time-multiplexed controller that runs a cascade of NSEC direct-form-I biquad sections on a single shared signed multiplier and accumulator. It holds per-section coefficients, shift values and x/y history. For each accepted input sample it sequences five multiply-accumulate taps plus one write-back per section, then presents the saturated result on a valid/ready output. It sits between the UART command/data parser, which drives the cfg and in ports, and the UART transmit path, which drives the out port.

---
 rtl/biquad_sequencer.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/biquad_sequencer.sv
// Cascade of NSEC direct-form-I biquads sharing one signed multiplier and accumulator.
// Latency: result valid 6*NSEC cycles after the input accept edge (5 taps + 1 write-back per section).
// Backpressure: in_ready only in IDLE; out_valid/out_data held until out_ready, no new input meanwhile.
module biquad_sequencer #(
    parameter int NSEC = 4,
    parameter int DW   = 16,
    parameter int ACCW = 40
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      cfg_we,
    input  logic [$clog2(NSEC)+2:0]   cfg_addr,
    input  logic [DW-1:0]             cfg_data,
    output logic                      cfg_ready,
    input  logic                      clr_state,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DW-1:0]             in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DW-1:0]             out_data,
    output logic                      busy
);

    localparam int AW = $clog2(NSEC) + 3;
    localparam int SW = (NSEC > 1) ? $clog2(NSEC) : 1;
    localparam int PW = 2 * DW;

    typedef struct packed {
        logic [DW-1:0] b0;
        logic [DW-1:0] b1;
        logic [DW-1:0] b2;
        logic [DW-1:0] a1;
        logic [DW-1:0] a2;
        logic [4:0]    shift;
    } coef_t;

    typedef struct packed {
        logic [DW-1:0] x1;
        logic [DW-1:0] x2;
        logic [DW-1:0] y1;
        logic [DW-1:0] y2;
    } hist_t;

    typedef enum logic [1:0] {IDLE, MAC, WB, OUT} state_t;

    localparam logic signed [ACCW-1:0] YMAX = {{(ACCW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [ACCW-1:0] YMIN = {{(ACCW-DW+1){1'b1}}, {(DW-1){1'b0}}};

    coef_t                  coef [NSEC];
    hist_t                  hist [NSEC];
    state_t                 state;
    logic [SW-1:0]          sec;
    logic [2:0]             tap;
    logic signed [ACCW-1:0] acc;
    logic [DW-1:0]          sec_x;

    logic signed [DW-1:0]   mul_a;
    logic signed [DW-1:0]   mul_b;
    logic signed [PW-1:0]   prod;
    logic signed [ACCW-1:0] prod_ext;
    logic signed [ACCW-1:0] acc_next;
    logic signed [ACCW-1:0] acc_sh;
    logic [DW-1:0]          y_sat;
    logic [AW-1:0]          cfg_sec;
    logic [2:0]             cfg_field;
    logic                   idle;

    assign idle      = (state == IDLE);
    assign in_ready  = idle;
    assign cfg_ready = idle;
    assign busy      = !idle;

    assign cfg_sec   = cfg_addr >> 3;
    assign cfg_field = cfg_addr[2:0];

    // Select coefficient and operand for the current tap; taps always see pre-sample history
    always_comb begin
        mul_a = '0;
        mul_b = '0;
        case (tap)
            3'd0: begin mul_a = $signed(coef[sec].b0); mul_b = $signed(sec_x);        end
            3'd1: begin mul_a = $signed(coef[sec].b1); mul_b = $signed(hist[sec].x1); end
            3'd2: begin mul_a = $signed(coef[sec].b2); mul_b = $signed(hist[sec].x2); end
            3'd3: begin mul_a = $signed(coef[sec].a1); mul_b = $signed(hist[sec].y1); end
            3'd4: begin mul_a = $signed(coef[sec].a2); mul_b = $signed(hist[sec].y2); end
            default: begin mul_a = '0; mul_b = '0; end
        endcase
    end

    assign prod     = mul_a * mul_b;
    assign prod_ext = {{(ACCW-PW){prod[PW-1]}}, prod};
    // Feedforward taps add, feedback taps (a1, a2) subtract
    assign acc_next = (tap >= 3'd3) ? (acc - prod_ext) : (acc + prod_ext);

    // Write-back value: arithmetic shift (floor) then clamp to the sample range
    assign acc_sh = acc >>> coef[sec].shift;
    always_comb begin
        y_sat = acc_sh[DW-1:0];
        if (acc_sh > YMAX)
            y_sat = {1'b0, {(DW-1){1'b1}}};
        else if (acc_sh < YMIN)
            y_sat = {1'b1, {(DW-1){1'b0}}};
    end

    // Coefficient store: writes land only while idle, otherwise silently dropped
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < NSEC; s++)
                coef[s] <= '0;
        end else if (cfg_we && idle) begin
            for (int s = 0; s < NSEC; s++) begin
                if (cfg_sec == AW'(s)) begin
                    case (cfg_field)
                        3'd0: coef[s].b0    <= cfg_data;
                        3'd1: coef[s].b1    <= cfg_data;
                        3'd2: coef[s].b2    <= cfg_data;
                        3'd3: coef[s].a1    <= cfg_data;
                        3'd4: coef[s].a2    <= cfg_data;
                        3'd5: coef[s].shift <= cfg_data[4:0];
                        default: ;
                    endcase
                end
            end
        end
    end

    // History store: cleared on request while idle, shifted at each section write-back
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < NSEC; s++)
                hist[s] <= '0;
        end else if (idle && clr_state) begin
            for (int s = 0; s < NSEC; s++)
                hist[s] <= '0;
        end else if (state == WB) begin
            hist[sec].x2 <= hist[sec].x1;
            hist[sec].x1 <= sec_x;
            hist[sec].y2 <= hist[sec].y1;
            hist[sec].y1 <= y_sat;
        end
    end

    // Sequencer: accept a sample, step five taps, write back, chain sections, hold the result
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            sec       <= '0;
            tap       <= '0;
            acc       <= '0;
            sec_x     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sec_x <= in_data;
                        sec   <= '0;
                        tap   <= '0;
                        acc   <= '0;
                        state <= MAC;
                    end
                end
                MAC: begin
                    acc <= acc_next;
                    if (tap == 3'd4)
                        state <= WB;
                    else
                        tap <= tap + 3'd1;
                end
                WB: begin
                    if (sec < SW'(NSEC - 1)) begin
                        sec   <= sec + SW'(1);
                        tap   <= '0;
                        acc   <= '0;
                        sec_x <= y_sat;
                        state <= MAC;
                    end else begin
                        out_data  <= y_sat;
                        out_valid <= 1'b1;
                        state     <= OUT;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
